// File: rtl/mod6_round_ctrl.sv
// Round controller for a modulo-6 counter: kicks the counter, checks the count sequence,
// and reports a phase decode, completed-round tally, done pulse and sticky error flag.
//
// state | meaning
// IDLE  | waiting for go while the counter is quiet
// KICK  | start is high; the counter must still read 0
// RUN   | every cycle, compare cnt against the expected count
// DONE  | one-cycle done pulse, then return to IDLE
module mod6_round_ctrl #(
    parameter int               LAST    = 5,
    parameter int               ROUND_W = 4,
    parameter logic [ROUND_W-1:0] TARGET  = 4'd3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [3:0]         cnt,
    input  logic               busy,
    output logic               start,
    output logic [LAST:0]      phase,
    output logic [ROUND_W-1:0] rounds,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KICK,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [3:0] LAST_C = 4'(LAST);

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [LAST:0]      phase_q, phase_d;
    logic [ROUND_W-1:0] rounds_q, rounds_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [3:0]         exp_q, exp_d;

    logic               cnt_match;
    logic               round_end;
    logic [ROUND_W-1:0] rounds_inc;

    assign cnt_match  = (cnt <= LAST_C) && (cnt == exp_q);
    assign round_end  = cnt_match && (cnt == LAST_C);
    assign rounds_inc = rounds_q + ROUND_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            phase_q  <= '0;
            rounds_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            exp_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            phase_q  <= phase_d;
            rounds_q <= rounds_d;
            done_q   <= done_d;
            err_q    <= err_d;
            exp_q    <= exp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        rounds_d = rounds_q;
        done_d   = 1'b0;
        err_d    = err_q;
        exp_d    = exp_q;

        // Out-of-range counts never match any bit, so phase falls to zero for them.
        phase_d = '0;
        for (int i = 0; i <= LAST; i++) begin
            phase_d[i] = (cnt == 4'(i));
        end

        case (state_q)
            ST_IDLE: begin
                if (go && !busy) begin
                    state_d  = ST_KICK;
                    start_d  = 1'b1;
                    rounds_d = '0;
                    err_d    = 1'b0;
                end
            end
            ST_KICK: begin
                if (cnt != 4'd0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    exp_d   = 4'd1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cnt_match) begin
                    err_d   = 1'b1;
                    exp_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (round_end) begin
                    rounds_d = rounds_inc;
                    exp_d    = 4'd0;
                    if (rounds_inc == TARGET) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Re-kick during the wrap-to-0 cycle so rounds run back to back.
                        start_d = 1'b1;
                    end
                end else begin
                    exp_d = exp_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign start  = start_q;
    assign phase  = phase_q;
    assign rounds = rounds_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: doc/mod6_round_ctrl.md
Name: mod6_round_ctrl

Overview:
- Controller paired with the modulo-6 synchronous counter. Drives the counter's `start` input and consumes its count `q` and busy flag `o3`.
- Runs the counter for a programmed number of complete rounds (0..LAST, then back to 0).
- Checks that the count sequence is legal.
- Produces a registered one-hot phase decode, a round tally and a done pulse for downstream logic.

Parameters:
- LAST, 5: final count value of a round; the legal count range is 0..LAST.
- ROUND_W, 4: width of the round tally.
- TARGET, 4'd3: rounds per run; must satisfy 1 ≤ TARGET ≤ 2^ROUND_W-1.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  request a run; sampled only in IDLE.
- cnt  in  4  counter value (counter `q`).
- busy  in  1  counter nonzero flag (counter `o3`).
- start  out  1  registered; one-cycle kick to the counter.
- phase  out  LAST+1  registered one-hot decode of cnt.
- rounds  out  ROUND_W  completed rounds in the current or last run.
- done  out  1  one-cycle pulse when TARGET rounds are complete.
- err  out  1  sticky sequence-error flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; start=0, phase=0, rounds=0, done=0, err=0, exp=0.
- States are IDLE, KICK, RUN, DONE.
- IDLE:
  - If go=1 and busy=0: go to KICK; clear rounds and err; set start=1 for the next cycle.
  - If go=1 and busy=1: ignore go; stay in IDLE.
- KICK (start=1):
  - cnt must be 0; otherwise set err and go to IDLE.
  - Set exp=1 and go to RUN.
- RUN: each cycle compare cnt with exp.
  - Mismatch, or cnt>LAST: set err, force start=0, go to IDLE. rounds holds its value.
  - Match, cnt<LAST: exp ← exp+1.
  - Match, cnt==LAST: rounds ← rounds+1 and exp ← 0.
    - If rounds+1==TARGET: go to DONE with start=0.
    - Otherwise: start=1 in the next cycle, while cnt==0 is expected. The cycle with cnt=0 is checked (exp=0), then exp ← 1.
  - No idle gap between rounds: each round lasts exactly LAST+1 cycles.
- DONE: done=1 for exactly one cycle; next state IDLE. cnt is not checked.
- start is a flop output. It is high only in the KICK cycle and in the cnt=0 cycle between rounds.
- phase:
  - phase[i]=1 one cycle after the cycle in which cnt==i, for i ≤ LAST.
  - phase=0 if cnt>LAST.
  - Decoded in all states.
- err:
  - Stays set until the next accepted go, which clears it at the IDLE→KICK edge, or until reset.
  - go and err both high in IDLE with busy=0: the run is accepted and err clears.
- rounds never wraps, because TARGET bounds it.
- Reset mid-run: all outputs drop immediately. The counter coasts to 0 on its own because start=0.
- go outside IDLE is ignored.

Test Plan:
- LAST=5, TARGET=2; counter model attached; go pulse in cycle 0 -> start=1 in cycles 1 and 7 only; cnt runs 0,1..5,0,1..5; rounds=1 after cycle 6 and 2 after cycle 12; done=1 in cycle 13 only; err=0 throughout.
- phase check across the same run -> phase=6'b000010 in cycle 3 (cnt=1 in cycle 2); phase=6'b100000 one cycle after each cnt=5.
- Inject cnt=3 where exp=2 in round 1 -> err=1 the next cycle; start stays 0; state IDLE; rounds=0; a later go with busy=0 clears err and starts a fresh run.
- go while busy=1 (cnt=4 forced) -> no KICK, start stays 0; go after busy=0 -> accepted.
- rst low during round 2, cnt=3 -> all outputs 0 asynchronously; after release, go restarts with rounds cleared.
- TARGET=1 -> exactly one round, single start pulse, done one cycle after cnt=5, rounds=1; go asserted in the DONE cycle is ignored.
